// File: rtl/selector_pkg.sv
// Shared encodings for the registered channel selector and its scan pointer.
package selector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_ptr_gen.sv
// Scan pointer: holds each channel for DWELL steps, freezes when step is low,
// and remembers that the last step wrapped so the pulse can ride with channel 0's data.
module scan_ptr_gen #(
  parameter int  NCH   = 4,
  parameter int  DWELL = 4,
  localparam int SELW  = $clog2(NCH),
  localparam int DCW   = $clog2(DWELL + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            step,
  input  logic            restart,
  output logic [SELW-1:0] cur_ptr,
  output logic            wrap_pend
);

  localparam logic [SELW-1:0] LAST_PTR   = SELW'(NCH - 1);
  localparam logic [DCW-1:0]  LAST_DWELL = DCW'(DWELL - 1);

  logic [SELW-1:0] ptr_q, ptr_d;
  logic [DCW-1:0]  dwell_q, dwell_d, cur_dwell;
  logic            wrap_q, wrap_d;

  // A restart consumes (0,0) in the same cycle, so the pointer is overridden here.
  assign cur_ptr   = restart ? '0 : ptr_q;
  assign cur_dwell = restart ? '0 : dwell_q;
  assign wrap_pend = wrap_q & ~restart;

  always_comb begin
    ptr_d   = ptr_q;
    dwell_d = dwell_q;
    wrap_d  = wrap_q;
    if (step) begin
      wrap_d = 1'b0;
      ptr_d  = cur_ptr;
      if (cur_dwell == LAST_DWELL) begin
        dwell_d = '0;
        if (cur_ptr == LAST_PTR) begin
          ptr_d  = '0;
          wrap_d = 1'b1;
        end else begin
          ptr_d = cur_ptr + SELW'(1);
        end
      end else begin
        dwell_d = cur_dwell + DCW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      dwell_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      dwell_q <= dwell_d;
      wrap_q  <= wrap_d;
    end
  end

endmodule

// File: rtl/selector_scan.sv
// N-channel registered selector with manual select and dwell-based auto scan.
// Every output is registered; the mode decided at an edge selects what that edge loads.
module selector_scan
  import selector_pkg::*;
#(
  parameter int  NCH   = 4,
  parameter int  DW    = 1,
  parameter int  DWELL = 4,
  localparam int SELW  = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*DW-1:0] din,
  input  logic [SELW-1:0]   sel,
  input  logic              en_n,
  input  logic              mode,
  output logic [DW-1:0]     dout,
  output logic [SELW-1:0]   dout_ch,
  output logic              dout_vld,
  output logic              scan_wrap
);

  state_e          state_q, state_d;
  logic            mode_q;
  logic            scan_step, scan_restart, scan_wrap_pend;
  logic [SELW-1:0] scan_ptr;

  logic [DW-1:0]   dout_q, dout_d;
  logic [SELW-1:0] dout_ch_q, dout_ch_d;
  logic            dout_vld_q, dout_vld_d;
  logic            scan_wrap_q, scan_wrap_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_MANUAL;
    end else begin
      state_q <= state_d;
      mode_q  <= mode;
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    if (!en_n) state_d = (mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
  end

  // Only a fresh manual->scan edge restarts; re-enabling from idle in scan mode resumes.
  assign scan_step    = (state_d == ST_SCAN);
  assign scan_restart = scan_step && (state_q != ST_SCAN) && (mode_q == MODE_MANUAL);

  scan_ptr_gen #(
    .NCH   (NCH),
    .DWELL (DWELL)
  ) u_ptr (
    .clk       (clk),
    .rst       (rst),
    .step      (scan_step),
    .restart   (scan_restart),
    .cur_ptr   (scan_ptr),
    .wrap_pend (scan_wrap_pend)
  );

  always_comb begin
    dout_d      = '0;
    dout_ch_d   = dout_ch_q;
    dout_vld_d  = 1'b0;
    scan_wrap_d = 1'b0;
    case (state_d)
      ST_MANUAL: begin
        dout_ch_d = sel;
        if (32'(sel) < NCH) begin
          dout_d     = din[sel*DW +: DW];
          dout_vld_d = 1'b1;
        end
      end
      ST_SCAN: begin
        dout_ch_d   = scan_ptr;
        dout_d      = din[scan_ptr*DW +: DW];
        dout_vld_d  = 1'b1;
        scan_wrap_d = scan_wrap_pend;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q      <= '0;
      dout_ch_q   <= '0;
      dout_vld_q  <= 1'b0;
      scan_wrap_q <= 1'b0;
    end else begin
      dout_q      <= dout_d;
      dout_ch_q   <= dout_ch_d;
      dout_vld_q  <= dout_vld_d;
      scan_wrap_q <= scan_wrap_d;
    end
  end

  assign dout      = dout_q;
  assign dout_ch   = dout_ch_q;
  assign dout_vld  = dout_vld_q;
  assign scan_wrap = scan_wrap_q;

endmodule

// File: tb/tb_selector_scan.sv
// Bench for selector_scan: directed vector table on the default build, hand sequences for
// DWELL=1 and NCH=3 builds, then random stimulus against a positional reference model.
module tb_selector_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] din = 32'h44332211;
  logic [1:0]  sel = 2'd0;
  logic        en_n = 1'b0;
  logic        mode = 1'b1;

  logic [7:0] dout_a [3];
  logic [1:0] ch_a   [3];
  logic       vld_a  [3];
  logic       wrap_a [3];

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  selector_scan #(.NCH(4), .DW(8), .DWELL(3)) u_main (
    .clk(clk), .rst(rst), .din(din), .sel(sel), .en_n(en_n), .mode(mode),
    .dout(dout_a[0]), .dout_ch(ch_a[0]), .dout_vld(vld_a[0]), .scan_wrap(wrap_a[0]));

  selector_scan #(.NCH(4), .DW(8), .DWELL(1)) u_d1 (
    .clk(clk), .rst(rst), .din(din), .sel(sel), .en_n(en_n), .mode(mode),
    .dout(dout_a[1]), .dout_ch(ch_a[1]), .dout_vld(vld_a[1]), .scan_wrap(wrap_a[1]));

  selector_scan #(.NCH(3), .DW(8), .DWELL(3)) u_n3 (
    .clk(clk), .rst(rst), .din(din[23:0]), .sel(sel), .en_n(en_n), .mode(mode),
    .dout(dout_a[2]), .dout_ch(ch_a[2]), .dout_vld(vld_a[2]), .scan_wrap(wrap_a[2]));

  // Reference model: scan position is a linear index into NCH*DWELL slots.
  int         m_pos     [3];
  bit         m_wrapped [3];
  bit         m_mprev   [3];
  logic [7:0] m_dout    [3];
  int         m_ch      [3];
  bit         m_vld     [3];
  bit         m_wrap    [3];

  function automatic int nch_of(int i);
    return (i == 2) ? 3 : 4;
  endfunction

  function automatic int dwell_of(int i);
    return (i == 1) ? 1 : 3;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int n;
      int d;
      n = nch_of(i);
      d = dwell_of(i);
      if (rst) begin
        m_pos[i] = 0; m_wrapped[i] = 0; m_mprev[i] = 0;
        m_dout[i] = 8'h00; m_ch[i] = 0; m_vld[i] = 0; m_wrap[i] = 0;
      end else begin
        if (en_n) begin
          m_dout[i] = 8'h00; m_vld[i] = 0; m_wrap[i] = 0;
        end else if (!mode) begin
          m_ch[i] = int'(sel);
          m_wrap[i] = 0;
          if (int'(sel) < n) begin
            m_dout[i] = din[int'(sel)*8 +: 8]; m_vld[i] = 1;
          end else begin
            m_dout[i] = 8'h00; m_vld[i] = 0;
          end
        end else begin
          if (!m_mprev[i]) begin
            m_pos[i] = 0; m_wrapped[i] = 0;
          end
          m_ch[i]   = m_pos[i] / d;
          m_dout[i] = din[m_ch[i]*8 +: 8];
          m_vld[i]  = 1;
          m_wrap[i] = m_wrapped[i];
          m_pos[i]  = (m_pos[i] + 1) % (n * d);
          m_wrapped[i] = (m_pos[i] == 0);
        end
        m_mprev[i] = mode;
      end
    end
  end

  typedef struct {
    logic       rst;
    logic       en_n;
    logic       mode;
    logic [1:0] sel;
    logic [7:0] dout;
    logic [1:0] ch;
    logic       vld;
    logic       wrap;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic r, logic e, logic m, logic [1:0] s,
                              logic [7:0] d, logic [1:0] c, logic v, logic w);
    vec_t x;
    x.rst = r; x.en_n = e; x.mode = m; x.sel = s;
    x.dout = d; x.ch = c; x.vld = v; x.wrap = w;
    tbl.push_back(x);
  endfunction

  task automatic drive(logic r, logic e, logic m, logic [1:0] s);
    rst = r; en_n = e; mode = m; sel = s;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, int inst, logic [7:0] d, int c, logic v, logic w);
    nvec++;
    if (dout_a[inst] !== d || ch_a[inst] !== 2'(c) || vld_a[inst] !== v || wrap_a[inst] !== w) begin
      nfail++;
      $display("FAIL %s inst%0d @%0t: got dout=%h ch=%0d vld=%b wrap=%b, want dout=%h ch=%0d vld=%b wrap=%b",
               nm, inst, $time, dout_a[inst], ch_a[inst], vld_a[inst], wrap_a[inst], d, c, v, w);
    end
  endtask

  initial begin
    // Reset held with scan requested, then released: scan starts at channel 0.
    add(1, 0, 1, 0, 8'h00, 0, 0, 0);
    add(1, 0, 1, 0, 8'h00, 0, 0, 0);
    add(0, 0, 1, 0, 8'h11, 0, 1, 0);
    // Manual select.
    add(0, 0, 0, 2, 8'h33, 2, 1, 0);
    add(0, 0, 0, 0, 8'h11, 0, 1, 0);
    // Fresh scan: three cycles per channel, wrap rides with the return to channel 0.
    for (int k = 0; k <= 18; k++)
      add(0, 0, 1, 0, 8'(17 * ((k / 3) % 4 + 1)), 2'((k / 3) % 4), 1, k == 12);
    // Pause on the 2nd cycle of channel 2, then resume where it froze.
    for (int k = 0; k < 5; k++) add(0, 1, 1, 0, 8'h00, 2, 0, 0);
    add(0, 0, 1, 0, 8'h33, 2, 1, 0);
    add(0, 0, 1, 0, 8'h33, 2, 1, 0);
    add(0, 0, 1, 0, 8'h44, 3, 1, 0);
    add(0, 0, 1, 0, 8'h44, 3, 1, 0);
    // Reset mid-scan restarts the scan from channel 0.
    add(1, 0, 1, 0, 8'h00, 0, 0, 0);
    add(0, 0, 1, 0, 8'h11, 0, 1, 0);
    add(0, 0, 1, 0, 8'h11, 0, 1, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].en_n, tbl[i].mode, tbl[i].sel);
      chk($sformatf("table[%0d]", i), 0, tbl[i].dout, int'(tbl[i].ch), tbl[i].vld, tbl[i].wrap);
    end

    // DWELL=1: channel advances every cycle, wrap every 4th output.
    drive(1, 0, 1, 0);
    for (int k = 0; k < 9; k++) begin
      drive(0, 0, 1, 0);
      chk("dwell1", 1, 8'(17 * (k % 4 + 1)), k % 4, 1, (k % 4 == 0) && (k > 0));
    end

    // NCH=3: out-of-range select yields invalid zero data but still tags the channel.
    drive(0, 0, 0, 3);
    chk("nch3_sel3", 2, 8'h00, 3, 0, 0);
    chk("nch4_sel3", 0, 8'h44, 3, 1, 0);
    drive(0, 0, 0, 2);
    chk("nch3_sel2", 2, 8'h33, 2, 1, 0);

    // Random traffic on all three builds against the model.
    for (int k = 0; k < 800; k++) begin
      logic r, e, m;
      r = ($urandom_range(0, 39) == 0);
      e = ($urandom_range(0, 5) == 0);
      m = ($urandom_range(0, 9) == 0) ? ~mode : mode;
      if ($urandom_range(0, 3) == 0) din = $urandom;
      drive(r, e, m, 2'($urandom_range(0, 3)));
      for (int i = 0; i < 3; i++)
        chk($sformatf("rand[%0d]", k), i, m_dout[i], m_ch[i], m_vld[i], m_wrap[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
